// File: rtl/foc_loop_scheduler.sv
// FOC current-loop scheduler: times the control period and sequences
// ADC -> Clarke/Park -> PI -> SVPWM with timeout and overrun supervision.
module foc_loop_scheduler #(
    parameter int unsigned PERIOD    = 5000,
    parameter int unsigned ADC_DELAY = 0,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iEnable,
    input  logic        iFault_clr,
    output logic        oAdc_start,
    input  logic        iAdc_done,
    output logic        oCoord_en,
    input  logic        iCoord_done,
    output logic        oPi_en,
    input  logic        iPi_done,
    output logic        oSvpwm_en,
    input  logic        iSvpwm_done,
    output logic        oPeriod_tick,
    output logic        oBusy,
    output logic        oLoop_done,
    output logic [15:0] oLoop_cycles,
    output logic        oFault,
    output logic [1:0]  oFault_stage,
    output logic        oOverrun
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADC, S_COORD, S_PI, S_SVPWM, S_FAULT
    } state_t;

    state_t      state;
    logic [15:0] cnt;
    logic [15:0] cnt_nxt;
    logic [15:0] timer;
    logic [15:0] lat;
    logic [15:0] lat_inc;
    logic        trig;
    logic        active;
    logic        done;
    logic [1:0]  stg;

    always_comb begin
        cnt_nxt = (cnt == 16'(PERIOD - 1)) ? 16'd0 : cnt + 16'd1;
        trig    = (cnt == 16'(ADC_DELAY));
        lat_inc = (lat == 16'hFFFF) ? lat : lat + 16'd1;
        active  = 1'b0;
        done    = 1'b0;
        stg     = 2'd0;
        unique case (state)
            S_ADC:   begin active = 1'b1; done = iAdc_done;   stg = 2'd0; end
            S_COORD: begin active = 1'b1; done = iCoord_done; stg = 2'd1; end
            S_PI:    begin active = 1'b1; done = iPi_done;    stg = 2'd2; end
            S_SVPWM: begin active = 1'b1; done = iSvpwm_done; stg = 2'd3; end
            default: ;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state        <= S_IDLE;
            cnt          <= 16'd0;
            timer        <= 16'd0;
            lat          <= 16'd0;
            oAdc_start   <= 1'b0;
            oCoord_en    <= 1'b0;
            oPi_en       <= 1'b0;
            oSvpwm_en    <= 1'b0;
            oPeriod_tick <= 1'b0;
            oBusy        <= 1'b0;
            oLoop_done   <= 1'b0;
            oLoop_cycles <= 16'd0;
            oFault       <= 1'b0;
            oFault_stage <= 2'd0;
            oOverrun     <= 1'b0;
        end else begin
            cnt          <= cnt_nxt;
            oPeriod_tick <= (cnt_nxt == 16'd0);
            oAdc_start   <= 1'b0;
            oCoord_en    <= 1'b0;
            oPi_en       <= 1'b0;
            oSvpwm_en    <= 1'b0;
            oLoop_done   <= 1'b0;
            if (active && trig)
                oOverrun <= 1'b1;
            else if (iFault_clr)
                oOverrun <= 1'b0;
            if (active)
                lat <= lat_inc;
            unique case (state)
                S_IDLE: begin
                    if (trig && iEnable) begin
                        state      <= S_ADC;
                        oAdc_start <= 1'b1;
                        oBusy      <= 1'b1;
                        timer      <= 16'd0;
                        lat        <= 16'd0;
                    end
                end
                S_FAULT: begin
                    if (iFault_clr) begin
                        state        <= S_IDLE;
                        oFault       <= 1'b0;
                        oFault_stage <= 2'd0;
                    end
                end
                default: begin
                    // timer==0 is the start-pulse cycle; a done there is ignored
                    if (done && timer != 16'd0) begin
                        timer <= 16'd0;
                        unique case (state)
                            S_ADC: begin
                                state     <= S_COORD;
                                oCoord_en <= 1'b1;
                            end
                            S_COORD: begin
                                state  <= S_PI;
                                oPi_en <= 1'b1;
                            end
                            S_PI: begin
                                state     <= S_SVPWM;
                                oSvpwm_en <= 1'b1;
                            end
                            default: begin
                                state        <= S_IDLE;
                                oBusy        <= 1'b0;
                                oLoop_done   <= 1'b1;
                                oLoop_cycles <= lat_inc;
                            end
                        endcase
                    end else if (timer == 16'(TIMEOUT)) begin
                        state        <= S_FAULT;
                        oBusy        <= 1'b0;
                        oFault       <= 1'b1;
                        oFault_stage <= stg;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
            endcase
        end
    end

endmodule
